addsub_acc_ctrl: RTL and testbench
==================================

// Module: addsub_acc_ctrl
// PURPOSE
//  Sequencer for the WIDTH-bit two's-complement add/sub datapath. After START it accepts
//  NUM operands over a valid/ready stream and applies ACC <= ACC +/- DATA_IN per OP.
//  Tracks the carry-out of the last step and a sticky signed-overflow flag, then pulses DONE.
//  Sits between a stimulus source (switches/test FSM) and the display/readback logic.
// PARAMETERS
//  WIDTH    8  datapath / accumulator width, two's complement
//  COUNT_W  4  width of operand-count field; max NUM = 2**COUNT_W-1
// PORTS
//  CLK       in   1        sole clock, rising edge
//  RST       in   1        synchronous, active-high reset
//  START     in   1        begin a sequence; sampled only in IDLE
//  NUM       in   COUNT_W  operand count, sampled with START
//  IN_VALID  in   1        DATA_IN/OP valid
//  IN_READY  out  1        controller accepts an operand this cycle
//  OP        in   1        0 = add, 1 = subtract (ACC - DATA_IN)
//  DATA_IN   in   WIDTH    operand
//  ACC       out  WIDTH    running/final result
//  CO        out  1        carry-out of last accepted step (sub: 1 = no borrow)
//  OVF       out  1        sticky: any step overflowed since START
//  BUSY      out  1        high in RUN and DONE
//  DONE      out  1        one-cycle pulse, result final
// BEHAVIOUR
//  - Reset (any state, incl. mid-sequence): state=IDLE; ACC=0, CO=0, OVF=0, DONE=0, BUSY=0,
//    IN_READY=0, count=0. Registers only; no output depends combinationally on inputs.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: IN_READY=0. START & NUM!=0: ACC<=0, CO<=0, OVF<=0, cnt<=NUM, -> RUN.
//    START & NUM==0: ACC<=0, CO<=0, OVF<=0, -> DONE (empty sequence). ACC/CO/OVF otherwise held.
//  - RUN: IN_READY=1 (registered, asserted the cycle after entering RUN). Transfer = IN_VALID & IN_READY.
//    On transfer: B' = OP ? ~DATA_IN : DATA_IN, cin = OP; {CO,ACC} <= ACC + B' + cin;
//    OVF <= OVF | ((ACC[MSB]&B'[MSB]&~S[MSB]) | (~ACC[MSB]&~B'[MSB]&S[MSB])); cnt <= cnt-1.
//    Transfer with cnt==1 -> DONE; IN_READY drops next cycle. No transfer: all held.
//  - DONE: DONE=1 exactly one cycle, BUSY=1, -> IDLE. ACC/CO/OVF held until next START.
//  - Arithmetic wraps modulo 2**WIDTH; no saturation. OVF is signed overflow only; CO is unsigned.
//  - START while BUSY ignored. START in same cycle as DONE->IDLE ignored (IDLE sampled next cycle).
//  - Latency: DONE asserts the cycle after the final transfer; throughput 1 operand/cycle.
// STRUCTURE
//  - Shared include addsub_defs.vh: state encodings (S_IDLE, S_RUN, S_DONE), OP_ADD=0, OP_SUB=1.
//  - One sub-module addsub_core #(WIDTH): combinational (A,B,OP)->(S,CO,V) adder using the sign
//    rule above; the controller holds all state, counter and handshake.
// TESTING
//  1 RST, NUM=3, ops +5,+10,-3 (WIDTH=8) -> ACC=0x0C, OVF=0, DONE pulse 1 cycle after 3rd transfer.
//  2 NUM=2, +100,+100 -> ACC=0xC8, OVF=1, CO=0; next START clears OVF to 0.
//  3 NUM=1, 0 - 0x80 -> ACC=0x80, OVF=1; NUM=1, 0 - 0x01 -> ACC=0xFF, CO=0, OVF=0.
//  4 IN_VALID toggled 1/0 per cycle, NUM=4 of +1 -> ACC=4, exactly 4 transfers, no extra accept.
//  5 START with NUM=0 -> DONE next cycle, ACC=0; START pulsed during RUN -> no effect.
//  6 RST asserted mid-RUN after 2 of 4 operands -> next cycle IDLE, all outputs 0, IN_READY=0.
//  Checker: reference model of ACC/CO/OVF per transfer; assert DONE width==1, IN_READY=0 outside RUN.

Source files
------------

// File: rtl/addsub_acc_ctrl_pkg.sv
// Shared types and helpers for the add/sub accumulator sequencer:
// FSM state encodings, operation codes and the signed-overflow rule.
package addsub_acc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow: both addends share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb);
  endfunction

endpackage

// File: rtl/addsub_acc_ctrl_core.sv
// Combinational two's-complement add/subtract stage: S = A + (OP ? ~B : B) + OP,
// with unsigned carry-out and signed overflow.
module addsub_acc_ctrl_core
  import addsub_acc_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_op,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_v
);

  logic [WIDTH-1:0] w_b;

  assign w_b = (i_op == OP_SUB) ? ~i_b : i_b;
  assign {o_co, o_s} = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_op};
  assign o_v = signed_ovf(i_a[WIDTH-1], w_b[WIDTH-1], o_s[WIDTH-1]);

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Sequencer for the add/sub datapath: after START it accepts NUM operands over a
// valid/ready stream, accumulates them, tracks carry and sticky overflow, then pulses DONE.
module addsub_acc_ctrl
  import addsub_acc_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [COUNT_W-1:0] i_num,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic               i_op,
  input  logic [WIDTH-1:0]   i_data_in,
  output logic [WIDTH-1:0]   o_acc,
  output logic               o_co,
  output logic               o_ovf,
  output logic               o_busy,
  output logic               o_done
);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_acc;
  logic               r_co;
  logic               r_ovf;
  logic [COUNT_W-1:0] r_cnt;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;

  logic               w_xfer;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum;
  logic               w_co;
  logic               w_v;

  assign w_xfer = i_in_valid & r_in_ready;
  assign w_last = (r_cnt == {{(COUNT_W-1){1'b0}}, 1'b1});

  addsub_acc_ctrl_core #(.WIDTH(WIDTH)) u_core (
    .i_a  (r_acc),
    .i_b  (i_data_in),
    .i_op (i_op),
    .o_s  (w_sum),
    .o_co (w_co),
    .o_v  (w_v)
  );

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_num != {COUNT_W{1'b0}}) begin
            w_state_next = S_RUN;
          end else begin
            w_state_next = S_DONE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_xfer && w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state so they track it exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == S_RUN);
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= (w_state_next == S_DONE);
    end
  end

  // Accumulator, flags and operand counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= {WIDTH{1'b0}};
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
      r_cnt <= {COUNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc <= {WIDTH{1'b0}};
            r_co  <= 1'b0;
            r_ovf <= 1'b0;
            r_cnt <= i_num;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_acc <= w_sum;
            r_co  <= w_co;
            r_ovf <= r_ovf | w_v;
            r_cnt <= r_cnt - {{(COUNT_W-1){1'b0}}, 1'b1};
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign o_acc      = r_acc;
  assign o_co       = r_co;
  assign o_ovf      = r_ovf;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_in_ready = r_in_ready;

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Scoreboard bench for addsub_acc_ctrl: stimulus pushes expected results from an
// integer-arithmetic reference model; a negedge monitor pops and compares.
module tb_addsub_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] num = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       op = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] acc;
  logic       co, ovf, busy, done;

  addsub_acc_ctrl #(.WIDTH(8), .COUNT_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_num      (num),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_op       (op),
    .i_data_in  (data_in),
    .o_acc      (acc),
    .o_co       (co),
    .o_ovf      (ovf),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [9:0] step_q[$];
  logic [9:0] done_q[$];
  logic       xfer_seen = 1'b0;
  logic       done_prev = 1'b0;
  logic [9:0] exp_e;

  bit         seq_op[0:15];
  logic [7:0] seq_d[0:15];

  logic [7:0] m_acc;
  logic       m_co, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test, unsigned compare for carry.
  task automatic model_step(input bit sub, input logic [7:0] d);
    int au, du, as_, ds, rs;
    au  = int'(m_acc);
    du  = int'(d);
    as_ = int'($signed(m_acc));
    ds  = int'($signed(d));
    rs  = sub ? as_ - ds : as_ + ds;
    m_co  = sub ? (au >= du) : ((au + du) > 255);
    m_ovf = m_ovf | (rs > 127) | (rs < -128);
    m_acc = 8'((sub ? au - du : au + du) & 255);
  endtask

  // Capture accepted transfers at the clock edge.
  always @(posedge clk) xfer_seen <= in_valid & in_ready & ~rst;

  // Monitor: compare per-step and final results, DONE width and idle IN_READY.
  always @(negedge clk) begin
    if (!rst) begin
      if (xfer_seen) begin
        if (step_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL extra_xfer: got unexpected accept required none at %0t", $time);
        end else begin
          exp_e = step_q.pop_front();
          chk("step_acc_co_ovf", {22'd0, acc, co, ovf}, {22'd0, exp_e});
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_width", {31'd0, done_prev}, 32'd0);
        if (done_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL spurious_done: got done=1 required 0 at %0t", $time);
        end else begin
          exp_e = done_q.pop_front();
          chk("final_acc_co_ovf", {22'd0, acc, co, ovf}, {22'd0, exp_e});
        end
      end
      if (!busy) chk("ready_idle", {31'd0, in_ready}, 32'd0);
    end
    done_prev = done & ~rst;
  end

  // vmode: 0 valid always, 1 valid toggling, 2 random valid.
  task automatic run_seq(input int n, input int vmode, input bit mid_start);
    int idx, cyc, exp_done;
    bit ph;
    m_acc = 8'd0; m_co = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      model_step(seq_op[i], seq_d[i]);
      step_q.push_back({m_acc, m_co, m_ovf});
    end
    done_q.push_back({m_acc, m_co, m_ovf});
    exp_done = done_cnt + 1;
    start = 1'b1; num = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_clear", {22'd0, acc, co, ovf}, 32'd0);
    if (n == 0) chk("empty_done", {31'd0, done}, 32'd1);
    idx = 0; cyc = 0; ph = 1'b1;
    while (idx < n && cyc < 200) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = ph; ph = ~ph; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      op = seq_op[idx]; data_in = seq_d[idx];
      start = mid_start && (idx == 1);
      num = 4'd7;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (idx < n) chk("xfer_timeout", idx, n);
    cyc = 0;
    while (done_cnt < exp_done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done_cnt, exp_done);
    @(posedge clk); #1;
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc, idx;
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {19'd0, acc, co, ovf, busy, done, in_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: +5 +10 -3
    seq_op[0] = 0; seq_d[0] = 8'd5;
    seq_op[1] = 0; seq_d[1] = 8'd10;
    seq_op[2] = 1; seq_d[2] = 8'd3;
    run_seq(3, 0, 1'b0);
    chk("t1_acc", {24'd0, acc}, 32'h0C);
    chk("t1_ovf", {31'd0, ovf}, 32'd0);

    // 2: +100 +100 overflows signed, no carry
    seq_op[0] = 0; seq_d[0] = 8'd100;
    seq_op[1] = 0; seq_d[1] = 8'd100;
    run_seq(2, 0, 1'b0);
    chk("t2_acc", {24'd0, acc}, 32'hC8);
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    chk("t2_co", {31'd0, co}, 32'd0);

    // 3: 0 - 0x80, then 0 - 0x01
    seq_op[0] = 1; seq_d[0] = 8'h80;
    run_seq(1, 0, 1'b0);
    chk("t3a_acc", {24'd0, acc}, 32'h80);
    chk("t3a_ovf", {31'd0, ovf}, 32'd1);
    seq_op[0] = 1; seq_d[0] = 8'h01;
    run_seq(1, 0, 1'b0);
    chk("t3b_acc_co_ovf", {22'd0, acc, co, ovf}, {22'd0, 8'hFF, 1'b0, 1'b0});

    // 4: toggling valid, four +1
    for (int i = 0; i < 4; i++) begin seq_op[i] = 0; seq_d[i] = 8'd1; end
    run_seq(4, 1, 1'b0);
    chk("t4_acc", {24'd0, acc}, 32'd4);

    // 5: empty sequence; START pulsed mid-run
    run_seq(0, 0, 1'b0);
    chk("t5_acc", {24'd0, acc}, 32'd0);
    for (int i = 0; i < 5; i++) begin seq_op[i] = 0; seq_d[i] = 8'(i + 1); end
    run_seq(5, 0, 1'b1);
    chk("t5_mid_start_acc", {24'd0, acc}, 32'd15);

    // 6: reset after 2 of 4 operands
    m_acc = 8'd0; m_co = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_step(1'b0, 8'd9);
      step_q.push_back({m_acc, m_co, m_ovf});
    end
    start = 1'b1; num = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 2 && cyc < 20) begin
      in_valid = 1'b1; op = 1'b0; data_in = 8'd9;
      if (in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("t6_two_xfers", idx, 2);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_outputs", {19'd0, acc, co, ovf, busy, done, in_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_still_idle", {30'd0, busy, in_ready}, 32'd0);
    chk("t6_step_q_empty", step_q.size(), 0);

    // Randomized sequences
    for (int s = 0; s < 25; s++) begin
      int n;
      n = $urandom_range(1, 15);
      for (int i = 0; i < n; i++) begin
        seq_op[i] = 1'($urandom_range(0, 1));
        seq_d[i]  = 8'($urandom);
      end
      run_seq(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    chk("final_step_q_empty", step_q.size(), 0);
    chk("final_done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
